inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, which is the first fetch address after reset.
REQ-002 SHALL have parameter MEM_WORDS, default 32, which is the instruction memory depth in 32-bit words.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port pc, output, 32 bits: fetch address driven to instruction memory, a registered value.
REQ-006 SHALL have port inst, input, 32 bits: instruction word returned combinationally for the current pc.
REQ-007 SHALL have port redirect_valid, input, 1 bit: branch/jump taken, from execute.
REQ-008 SHALL have port redirect_pc, input, 32 bits: redirect target address.
REQ-009 SHALL have port id_ready, input, 1 bit: the decode stage accepts id_* this cycle.
REQ-010 SHALL have port id_valid, output, 1 bit: id_inst, id_pc and id_pc_plus4 hold a valid instruction.
REQ-011 SHALL have port id_inst, output, 32 bits: the fetched instruction.
REQ-012 SHALL have port id_pc, output, 32 bits: the address of id_inst.
REQ-013 SHALL have port id_pc_plus4, output, 32 bits: id_pc+4, used as the link value for jal/jalr.
REQ-014 SHALL have port halted, output, 1 bit: the processor has stopped; remains 1 until rst.

Function
REQ-015 SHALL implement states FETCH, HALTING and HALTED.
REQ-016 In FETCH, "load" SHALL be (!id_valid || id_ready) && !redirect_valid && !halt_cond; on load: id_inst<=inst, id_pc<=pc, id_pc_plus4<=pc+4, id_valid<=1, pc<=pc+4.
REQ-017 In FETCH, if (!id_valid || id_ready) and no load occurs, id_valid SHALL go to 0 (a bubble); if id_valid && !id_ready, all id_* and pc SHALL hold (stall).
REQ-018 halt_cond SHALL be inst[6:0]==7'h7F, or pc >= MEM_WORDS*4 (out of range).
REQ-019 The halt word SHALL never be presented on id_*.
REQ-020 In FETCH, on halt_cond with no redirect: pc SHALL hold and the state SHALL go to HALTING.
REQ-021 In HALTING, the state SHALL go to HALTED in the first cycle where id_valid==0, or id_valid && id_ready (the last instruction accepted); id_valid SHALL clear on that acceptance.
REQ-022 In HALTED: halted=1, id_valid=0, pc frozen; redirect_valid and id_ready are ignored.
REQ-023 redirect_valid in FETCH or HALTING SHALL: set pc<=redirect_pc with bits [1:0] forced to 2'b00, set id_valid<=0 (flush) on the same edge, and move the state to FETCH; redirect has priority over stall, load and halt_cond.
REQ-024 Fetch latency SHALL be one cycle: an instruction at pc appears on id_* at the next edge.
REQ-025 After a redirect, the first target instruction SHALL be valid 2 cycles after the redirect cycle.
REQ-026 pc+4 SHALL wrap modulo 2^32: 32'hFFFFFFFC -> 32'h00000000.
REQ-027 id_* SHALL only change when id_valid==0, or on the edge of a handshake (id_valid && id_ready), or on flush.

Reset
REQ-028 On rst=1 at a clock edge: pc<=RESET_PC, state<=FETCH, id_valid<=0, id_inst<=32'h00000013 (NOP), id_pc<=0, id_pc_plus4<=0, halted<=0.
REQ-029 rst SHALL take priority over all other inputs, including mid-stall, in HALTING and in HALTED.

Configuration
REQ-030 With macro INST_FETCH_PERF_EN defined, the block SHALL add 32-bit outputs perf_fetched and perf_stalls, both reset to 0, saturating at 32'hFFFFFFFF.
REQ-031 perf_fetched SHALL count load cycles; perf_stalls SHALL count FETCH cycles with id_valid && !id_ready.
REQ-032 Without INST_FETCH_PERF_EN, neither these ports nor the counters SHALL exist, and behaviour SHALL be otherwise identical.

Structure
REQ-033 A shared package SHALL hold HALT_OPCODE (7'h7F), NOP_INST (32'h00000013) and the fetch-state enum type; decode SHALL reuse HALT_OPCODE and NOP_INST from it.
REQ-034 The counters SHALL be a sub-module inst_fetch_perf, instantiated only under INST_FETCH_PERF_EN; fetch logic SHALL be a single module.

Verification
REQ-035 Reset then id_ready=1 with memory holding 0x00800293, 0x00F00313, 0x0000007F -> id_pc 0 then 4 on consecutive cycles, then halted=1 two cycles later, with pc frozen at 8.
REQ-036 id_ready=0 for 3 cycles while id_valid=1 -> id_*, pc hold; then id_ready=1 -> next instruction presented; perf_stalls==3 with the macro defined.
REQ-037 redirect_valid=1, redirect_pc=32'h00000013 while stalled -> pc=32'h10, id_valid=0 next cycle, id_pc=32'h10 valid the cycle after.
REQ-038 Halt word fetched and redirect asserted in the same cycle -> no halt, pc=redirect target; and halt followed by redirect while in HALTING -> returns to FETCH with halted=0.
REQ-039 MEM_WORDS=4, straight-line code -> after id_pc=12 is accepted, halted=1 with pc=16; rst asserted in HALTED -> pc=RESET_PC, halted=0 next cycle.
REQ-040 RESET_PC=32'hFFFFFFFC, MEM_WORDS set so pc is in range -> next pc is 32'h00000000.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared fetch/decode definitions: halt opcode, canonical NOP and fetch-state encoding.
package inst_fetch_pkg;

  localparam logic [6:0]  HALT_OPCODE = 7'h7F;
  localparam logic [31:0] NOP_INST    = 32'h00000013;

  typedef enum logic [1:0] {
    FETCH,
    HALTING,
    HALTED
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_perf.sv
// Saturating fetch/stall event counters for the instruction fetch stage.
module inst_fetch_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        stall_cycle,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalls
);

  // Each counter sticks at all-ones rather than wrapping back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= 32'h0;
      perf_stalls  <= 32'h0;
    end else begin
      if (load && (perf_fetched != 32'hFFFFFFFF))
        perf_fetched <= perf_fetched + 32'd1;
      if (stall_cycle && (perf_stalls != 32'hFFFFFFFF))
        perf_stalls <= perf_stalls + 32'd1;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage with stall/flush handshake and halt detection.
// Optional counters are added when INST_FETCH_PERF_EN is defined.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter int          MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        halted
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalls
`endif
);

  // 33 bits so a memory reaching the top of the address space still compares correctly.
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

  fetch_state_e state, state_next;
  logic [31:0]  pc_next, id_inst_next, id_pc_next, id_pc_plus4_next;
  logic         id_valid_next;
  logic [31:0]  pc_plus4;
  logic         halt_cond, slot_free, load;

  assign pc_plus4  = pc + 32'd4;
  assign halt_cond = (inst[6:0] == HALT_OPCODE) || ({1'b0, pc} >= MEM_BYTES);
  assign slot_free = !id_valid || id_ready;
  assign load      = (state == FETCH) && slot_free && !redirect_valid && !halt_cond;
  assign halted    = (state == HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      id_valid    <= 1'b0;
      id_inst     <= NOP_INST;
      id_pc       <= 32'h0;
      id_pc_plus4 <= 32'h0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      id_valid    <= id_valid_next;
      id_inst     <= id_inst_next;
      id_pc       <= id_pc_next;
      id_pc_plus4 <= id_pc_plus4_next;
    end
  end

  // Redirect outranks everything; a halt word is never loaded, only waited out.
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    id_valid_next    = id_valid;
    id_inst_next     = id_inst;
    id_pc_next       = id_pc;
    id_pc_plus4_next = id_pc_plus4;
    unique case (state)
      FETCH: begin
        if (redirect_valid) begin
          pc_next       = redirect_pc & 32'hFFFFFFFC;
          id_valid_next = 1'b0;
        end else begin
          if (load) begin
            id_inst_next     = inst;
            id_pc_next       = pc;
            id_pc_plus4_next = pc_plus4;
            id_valid_next    = 1'b1;
            pc_next          = pc_plus4;
          end else if (slot_free) begin
            id_valid_next = 1'b0;
          end
          if (halt_cond)
            state_next = HALTING;
        end
      end
      HALTING: begin
        if (redirect_valid) begin
          state_next    = FETCH;
          pc_next       = redirect_pc & 32'hFFFFFFFC;
          id_valid_next = 1'b0;
        end else if (slot_free) begin
          state_next    = HALTED;
          id_valid_next = 1'b0;
        end
      end
      HALTED: begin
        id_valid_next = 1'b0;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

`ifdef INST_FETCH_PERF_EN
  logic stall_cycle;
  assign stall_cycle = (state == FETCH) && id_valid && !id_ready;

  inst_fetch_perf u_perf (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .stall_cycle  (stall_cycle),
    .perf_fetched (perf_fetched),
    .perf_stalls  (perf_stalls)
  );
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a randomized
// stream checked by an instruction-order scoreboard.
module tb_inst_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, redirect_valid, id_ready;
  logic [31:0] redirect_pc, inst, pc, id_inst, id_pc, id_pc_plus4;
  logic        id_valid, halted;
  logic [31:0] mem [0:31];

  logic [31:0] b_pc, b_id_inst, b_id_pc, b_id_pc_plus4;
  logic        b_id_valid, b_halted;
  logic [31:0] c_pc, c_id_inst, c_id_pc, c_id_pc_plus4;
  logic        c_id_valid, c_halted;
`ifdef INST_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stalls, b_perf_fetched, b_perf_stalls, c_perf_fetched, c_perf_stalls;
`endif

  int compared   = 0;
  int mismatched = 0;

  assign inst = (pc < 32'd128) ? mem[pc[6:2]] : 32'h00000013;

  inst_fetch dut (
    .clk(clk), .rst(rst), .pc(pc), .inst(inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .halted(halted)
`ifdef INST_FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stalls(perf_stalls)
`endif
  );

  inst_fetch #(.MEM_WORDS(4)) dut_b (
    .clk(clk), .rst(rst), .pc(b_pc), .inst(32'h00000013),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .id_ready(1'b1),
    .id_valid(b_id_valid), .id_inst(b_id_inst), .id_pc(b_id_pc), .id_pc_plus4(b_id_pc_plus4),
    .halted(b_halted)
`ifdef INST_FETCH_PERF_EN
    , .perf_fetched(b_perf_fetched), .perf_stalls(b_perf_stalls)
`endif
  );

  inst_fetch #(.RESET_PC(32'hFFFFFFFC), .MEM_WORDS(1 << 30)) dut_c (
    .clk(clk), .rst(rst), .pc(c_pc), .inst(32'h00000013),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .id_ready(1'b1),
    .id_valid(c_id_valid), .id_inst(c_id_inst), .id_pc(c_id_pc), .id_pc_plus4(c_id_pc_plus4),
    .halted(c_halted)
`ifdef INST_FETCH_PERF_EN
    , .perf_fetched(c_perf_fetched), .perf_stalls(c_perf_stalls)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
    rst            = r;
    id_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] expWord(input logic [31:0] a);
    return (a < 32'd128) ? mem[a[6:2]] : 32'h00000013;
  endfunction

  // A stream may only stop at an address holding a halt word or past the memory end.
  function automatic logic isHaltPos(input logic [31:0] a);
    logic [31:0] w;
    if (a >= 32'd128) return 1'b1;
    w = mem[a[6:2]];
    return w[6:0] == 7'h7F;
  endfunction

  task automatic fillRandomMem();
    logic [31:0] w;
    for (int i = 0; i < 32; i++) begin
      w = $urandom;
      if ($urandom_range(0, 9) == 0) w[6:0] = 7'h7F;
      else if (w[6:0] == 7'h7F) w[0] = 1'b0;
      mem[i] = w;
    end
  endtask

  logic [31:0] exp_addr, snap_pc, snap_inst, snap_fpc, flush_target, rpc;
  logic        stall_pending, flush_pending, rdy, rv;
  int          idle;

  initial begin
    rst = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

    // Straight-line program ending in a halt word, plus the wrap-around instance.
    for (int i = 0; i < 32; i++) mem[i] = 32'h00000013;
    mem[0] = 32'h00800293; mem[1] = 32'h00F00313; mem[2] = 32'h0000007F;
    applyStimulus(1, 1, 0, 32'h0);
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_valid", 32'(id_valid), 32'h0);
    checkOutput("rst_inst", id_inst, 32'h00000013);
    checkOutput("rst_id_pc", id_pc, 32'h0);
    checkOutput("rst_plus4", id_pc_plus4, 32'h0);
    checkOutput("rst_halted", 32'(halted), 32'h0);
    checkOutput("wrap_rst_pc", c_pc, 32'hFFFFFFFC);
    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("f0_valid", 32'(id_valid), 32'h1);
    checkOutput("f0_id_pc", id_pc, 32'h0);
    checkOutput("f0_inst", id_inst, 32'h00800293);
    checkOutput("f0_plus4", id_pc_plus4, 32'h4);
    checkOutput("f0_pc", pc, 32'h4);
    checkOutput("wrap_id_pc", c_id_pc, 32'hFFFFFFFC);
    checkOutput("wrap_plus4", c_id_pc_plus4, 32'h0);
    checkOutput("wrap_pc", c_pc, 32'h0);
    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("f1_id_pc", id_pc, 32'h4);
    checkOutput("f1_inst", id_inst, 32'h00F00313);
    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("halting_valid", 32'(id_valid), 32'h0);
    checkOutput("halting_halted", 32'(halted), 32'h0);
    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("halted", 32'(halted), 32'h1);
    checkOutput("halted_pc", pc, 32'h8);
    applyStimulus(0, 1, 1, 32'h40);
    checkOutput("halted_ignore_redir", 32'(halted), 32'h1);
    checkOutput("halted_frozen_pc", pc, 32'h8);
    checkOutput("halted_valid", 32'(id_valid), 32'h0);

    // Three-cycle decode stall, then redirect while stalled.
    for (int i = 0; i < 32; i++) mem[i] = 32'h00000013 | (i << 7);
    applyStimulus(1, 1, 0, 32'h0);
    applyStimulus(0, 1, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 32'h0);
      checkOutput("stall_id_pc", id_pc, 32'h0);
      checkOutput("stall_inst", id_inst, 32'h00000013);
      checkOutput("stall_valid", 32'(id_valid), 32'h1);
      checkOutput("stall_pc", pc, 32'h4);
    end
    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("unstall_id_pc", id_pc, 32'h4);
    checkOutput("unstall_inst", id_inst, 32'h00000093);
`ifdef INST_FETCH_PERF_EN
    checkOutput("perf_stalls", perf_stalls, 32'd3);
    checkOutput("perf_fetched", perf_fetched, 32'd2);
`endif
    applyStimulus(0, 0, 0, 32'h0);
    checkOutput("stall2_pc", pc, 32'h8);
    applyStimulus(0, 0, 1, 32'h13);
    checkOutput("redir_pc", pc, 32'h10);
    checkOutput("redir_flush", 32'(id_valid), 32'h0);
    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("redir_valid", 32'(id_valid), 32'h1);
    checkOutput("redir_id_pc", id_pc, 32'h10);
    checkOutput("redir_inst", id_inst, 32'h00000213);

    // Redirect beats a halt word fetched in the same cycle; redirect rescues HALTING.
    mem[8] = 32'h0000007F;
    applyStimulus(0, 1, 1, 32'h20);
    applyStimulus(0, 1, 1, 32'h40);
    checkOutput("halt_vs_redir_pc", pc, 32'h40);
    checkOutput("halt_vs_redir_halted", 32'(halted), 32'h0);
    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("halt_vs_redir_id_pc", id_pc, 32'h40);
    applyStimulus(0, 1, 1, 32'h1C);
    applyStimulus(0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 32'h0);
    checkOutput("halting_hold_id_pc", id_pc, 32'h1C);
    checkOutput("halting_hold_valid", 32'(id_valid), 32'h1);
    checkOutput("halting_hold_pc", pc, 32'h20);
    applyStimulus(0, 0, 1, 32'h44);
    checkOutput("rescue_pc", pc, 32'h44);
    checkOutput("rescue_valid", 32'(id_valid), 32'h0);
    applyStimulus(0, 1, 0, 32'h0);
    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("rescue_id_pc", id_pc, 32'h48);
    checkOutput("rescue_halted", 32'(halted), 32'h0);

    // Four-word memory: halt on running off the end, then reset out of HALTED.
    applyStimulus(1, 1, 0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 32'h0);
      checkOutput("small_id_pc", b_id_pc, 32'(i * 4));
      checkOutput("small_valid", 32'(b_id_valid), 32'h1);
    end
    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("small_halting_valid", 32'(b_id_valid), 32'h0);
    checkOutput("small_halting", 32'(b_halted), 32'h0);
    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("small_halted", 32'(b_halted), 32'h1);
    checkOutput("small_halted_pc", b_pc, 32'h10);
    applyStimulus(1, 1, 0, 32'h0);
    checkOutput("small_rst_pc", b_pc, 32'h0);
    checkOutput("small_rst_halted", 32'(b_halted), 32'h0);

    // Random stream: accepted instructions must follow program order from the last target.
    fillRandomMem();
    applyStimulus(1, 0, 0, 32'h0);
    exp_addr = 32'h0; stall_pending = 1'b0; flush_pending = 1'b0; idle = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (flush_pending) begin
        checkOutput("rnd_flush_valid", 32'(id_valid), 32'h0);
        checkOutput("rnd_flush_pc", pc, flush_target);
      end else if (stall_pending) begin
        checkOutput("rnd_hold_id_pc", id_pc, snap_pc);
        checkOutput("rnd_hold_inst", id_inst, snap_inst);
        checkOutput("rnd_hold_valid", 32'(id_valid), 32'h1);
        checkOutput("rnd_hold_pc", pc, snap_fpc);
      end
      if (id_valid) checkOutput("rnd_no_halt_word", 32'(id_inst[6:0] == 7'h7F), 32'h0);
      if (halted || idle > 64) begin
        if (halted) begin
          checkOutput("rnd_halt_pc", pc, exp_addr);
          checkOutput("rnd_halt_legit", 32'(isHaltPos(exp_addr)), 32'h1);
          checkOutput("rnd_halt_valid", 32'(id_valid), 32'h0);
        end else begin
          checkOutput("rnd_progress", 32'(idle), 32'h0);
        end
        fillRandomMem();
        applyStimulus(1, 0, 0, 32'h0);
        exp_addr = 32'h0; stall_pending = 1'b0; flush_pending = 1'b0; idle = 0;
        continue;
      end
      rdy = ($urandom_range(0, 2) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      rpc = $urandom_range(0, 139);
      if (id_valid && rdy) begin
        checkOutput("rnd_hs_pc", id_pc, exp_addr);
        checkOutput("rnd_hs_inst", id_inst, expWord(exp_addr));
        checkOutput("rnd_hs_plus4", id_pc_plus4, exp_addr + 32'd4);
        exp_addr = exp_addr + 32'd4;
        idle = 0;
      end else begin
        idle++;
      end
      stall_pending = id_valid && !rdy && !rv;
      snap_pc = id_pc; snap_inst = id_inst; snap_fpc = pc;
      flush_pending = rv;
      if (rv) begin
        flush_target = rpc & 32'hFFFFFFFC;
        exp_addr = flush_target;
        idle = 0;
      end
      applyStimulus(0, rdy, rv, rpc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
